// File: rtl/cpu_pkg.sv
// Shared CPU pipeline-control definitions.
// State encodings, mul/div latency default and register index width.
package cpu_pkg;

    localparam int REG_W         = 4;
    localparam int MD_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01,
        ST_HALT    = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector.
// Flags an ID-stage read of a register that a load in EX has yet to write.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic             i_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_hazard
);

    logic w_rd_nz;
    logic w_match;

    // R0 is hardwired zero, so a load into it never creates a dependency
    always_comb begin
        w_rd_nz  = (i_ex_rd != '0);
        w_match  = (i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt);
        o_hazard = i_mem_read & w_rd_nz & w_match;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stalls, flushes, mul/div hold and HALT.
// Control outputs react combinationally to the current state and inputs.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegRD,
    input  logic [REG_W-1:0] IFID_RS,
    input  logic [REG_W-1:0] IFID_RT,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             halt_op,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_FLUSH,
    output logic             IDEX_Write,
    output logic             IDEX_FLUSH,
    output logic             EXM_FLUSH,
    output logic             alu_hold,
    output logic             md_done,
    output logic [1:0]       ctrl_state,
    output logic [15:0]      stall_cnt
);

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    ctrl_state_e r_state;
    logic [7:0]  r_md_cnt;
    logic        r_md_done;
    logic [15:0] r_stall_cnt;
    logic        w_hazard;
    logic        w_md_go;

    hazard_detect u_hazard (
        .i_mem_read (IDEX_MemRead),
        .i_ex_rd    (IDEX_RegRD),
        .i_id_rs    (IFID_RS),
        .i_id_rt    (IFID_RT),
        .o_hazard   (w_hazard)
    );

    // md_start seen in the md_done cycle is the finishing op itself
    assign w_md_go    = md_start & ~r_md_done;
    assign md_done    = r_md_done;
    assign ctrl_state = r_state;
    assign stall_cnt  = r_stall_cnt;

    // Per-state control outputs; branch beats every other request in RUN
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IDEX_Write = 1'b1;
        IFID_FLUSH = 1'b0;
        IDEX_FLUSH = 1'b0;
        EXM_FLUSH  = 1'b0;
        alu_hold   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    IFID_FLUSH = 1'b1;
                    IDEX_FLUSH = 1'b1;
                end else if (w_md_go) begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Write = 1'b0;
                    EXM_FLUSH  = 1'b1;
                    alu_hold   = 1'b1;
                end else if (w_hazard) begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_FLUSH = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Write = 1'b0;
                EXM_FLUSH  = 1'b1;
                alu_hold   = 1'b1;
            end
            ST_HALT: begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_FLUSH = 1'b1;
            end
            default: ;
        endcase
    end

    // State, mul/div countdown and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_md_cnt  <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        r_state <= ST_RUN;
                    end else if (w_md_go) begin
                        r_state  <= ST_MD_BUSY;
                        r_md_cnt <= MD_LOAD;
                    end else if (w_hazard) begin
                        r_state <= ST_RUN;
                    end else if (halt_op) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_MD_BUSY: begin
                    r_md_cnt <= r_md_cnt - 8'd1;
                    if (r_md_cnt <= 8'd1) begin
                        r_state   <= ST_RUN;
                        r_md_done <= 1'b1;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of stall cycles, HALT excluded
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!PC_Write && r_state != ST_HALT
                     && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        IDEX_MemRead;
    logic [3:0]  IDEX_RegRD;
    logic [3:0]  IFID_RS;
    logic [3:0]  IFID_RT;
    logic        md_start;
    logic        branch_taken;
    logic        halt_op;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_FLUSH;
    logic        IDEX_Write;
    logic        IDEX_FLUSH;
    logic        EXM_FLUSH;
    logic        alu_hold;
    logic        md_done;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;

    int n_vec;
    int n_err;

    pipeline_ctrl #(.MD_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_RegRD   (IDEX_RegRD),
        .IFID_RS      (IFID_RS),
        .IFID_RT      (IFID_RT),
        .md_start     (md_start),
        .branch_taken (branch_taken),
        .halt_op      (halt_op),
        .PC_Write     (PC_Write),
        .IFID_Write   (IFID_Write),
        .IFID_FLUSH   (IFID_FLUSH),
        .IDEX_Write   (IDEX_Write),
        .IDEX_FLUSH   (IDEX_FLUSH),
        .EXM_FLUSH    (EXM_FLUSH),
        .alu_hold     (alu_hold),
        .md_done      (md_done),
        .ctrl_state   (ctrl_state),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IDEX_MemRead = 1'b0;
        IDEX_RegRD   = 4'd0;
        IFID_RS      = 4'd0;
        IFID_RT      = 4'd0;
        md_start     = 1'b0;
        branch_taken = 1'b0;
        halt_op      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (ctrl_state !== 2'b00 || stall_cnt !== 16'd0 || md_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state=%b cnt=%0d done=%b want 00/0/0",
                     ctrl_state, stall_cnt, md_done);
        end
        n_vec++;
        if ({PC_Write, IFID_Write, IDEX_Write, IFID_FLUSH, IDEX_FLUSH,
             EXM_FLUSH, alu_hold} !== 7'b1110000) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 1110000",
                     {PC_Write, IFID_Write, IDEX_Write, IFID_FLUSH,
                      IDEX_FLUSH, EXM_FLUSH, alu_hold});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        IDEX_MemRead = 1'b1;
        IDEX_RegRD   = 4'd3;
        IFID_RS      = 4'd3;
        IFID_RT      = 4'd7;
        #1;
        n_vec++;
        if ({PC_Write, IFID_Write, IDEX_FLUSH} !== 3'b001) begin
            n_err++;
            $display("FAIL load_use_rs: pc/ifid/flush=%b want 001",
                     {PC_Write, IFID_Write, IDEX_FLUSH});
        end
        step();
        idle_inputs();
        #1;
        n_vec++;
        if (PC_Write !== 1'b1 || IDEX_FLUSH !== 1'b0 || stall_cnt !== 16'd1
            || ctrl_state !== 2'b00) begin
            n_err++;
            $display("FAIL load_use_after: pc=%b flush=%b cnt=%0d st=%b want 1/0/1/00",
                     PC_Write, IDEX_FLUSH, stall_cnt, ctrl_state);
        end
        IDEX_MemRead = 1'b1;
        IDEX_RegRD   = 4'd5;
        IFID_RS      = 4'd1;
        IFID_RT      = 4'd5;
        #1;
        n_vec++;
        if (PC_Write !== 1'b0 || IDEX_FLUSH !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_rt: pc=%b flush=%b want 0/1",
                     PC_Write, IDEX_FLUSH);
        end
        IDEX_MemRead = 1'b0;
        #1;
        n_vec++;
        if (PC_Write !== 1'b1) begin
            n_err++;
            $display("FAIL no_load_no_stall: pc=%b want 1", PC_Write);
        end
        step();
        n_vec++;
        if (stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL load_use_cnt: cnt=%0d want 1", stall_cnt);
        end
    endtask

    task automatic test_r0_exempt();
        do_reset();
        IDEX_MemRead = 1'b1;
        IDEX_RegRD   = 4'd0;
        IFID_RS      = 4'd0;
        IFID_RT      = 4'd0;
        #1;
        n_vec++;
        if (PC_Write !== 1'b1 || IDEX_FLUSH !== 1'b0) begin
            n_err++;
            $display("FAIL r0_exempt: pc=%b flush=%b want 1/0",
                     PC_Write, IDEX_FLUSH);
        end
        step();
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL r0_cnt: cnt=%0d want 0", stall_cnt);
        end
    endtask

    task automatic test_branch_override();
        do_reset();
        IDEX_MemRead = 1'b1;
        IDEX_RegRD   = 4'd3;
        IFID_RS      = 4'd3;
        branch_taken = 1'b1;
        md_start     = 1'b1;
        halt_op      = 1'b1;
        #1;
        n_vec++;
        if ({PC_Write, IFID_FLUSH, IDEX_FLUSH, EXM_FLUSH, alu_hold}
            !== 5'b11100) begin
            n_err++;
            $display("FAIL branch_outs: pc/iff/idf/exf/hold=%b want 11100",
                     {PC_Write, IFID_FLUSH, IDEX_FLUSH, EXM_FLUSH, alu_hold});
        end
        step();
        idle_inputs();
        #1;
        n_vec++;
        if (ctrl_state !== 2'b00 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL branch_after: st=%b cnt=%0d want 00/0",
                     ctrl_state, stall_cnt);
        end
    endtask

    task automatic test_muldiv();
        int bad;
        do_reset();
        md_start = 1'b1;
        #1;
        n_vec++;
        if ({PC_Write, IFID_Write, IDEX_Write, EXM_FLUSH, alu_hold}
            !== 5'b00011) begin
            n_err++;
            $display("FAIL md_start_outs: got %b want 00011",
                     {PC_Write, IFID_Write, IDEX_Write, EXM_FLUSH, alu_hold});
        end
        step();
        md_start = 1'b0;
        branch_taken = 1'b1;
        halt_op = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (ctrl_state !== 2'b01 || PC_Write !== 1'b0 || md_done !== 1'b0
                || alu_hold !== 1'b1 || IFID_FLUSH !== 1'b0)
                bad++;
            step();
        end
        branch_taken = 1'b0;
        halt_op = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL md_busy_hold: %0d bad cycles want 0", bad);
        end
        md_start = 1'b1;
        #1;
        n_vec++;
        if (md_done !== 1'b1 || ctrl_state !== 2'b00 || PC_Write !== 1'b1
            || stall_cnt !== 16'd16) begin
            n_err++;
            $display("FAIL md_done: done=%b st=%b pc=%b cnt=%0d want 1/00/1/16",
                     md_done, ctrl_state, PC_Write, stall_cnt);
        end
        step();
        md_start = 1'b0;
        #1;
        n_vec++;
        if (md_done !== 1'b0 || ctrl_state !== 2'b00 || stall_cnt !== 16'd16) begin
            n_err++;
            $display("FAIL md_restart_ignored: done=%b st=%b cnt=%0d want 0/00/16",
                     md_done, ctrl_state, stall_cnt);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        halt_op      = 1'b1;
        IDEX_MemRead = 1'b1;
        IDEX_RegRD   = 4'd4;
        IFID_RT      = 4'd4;
        step();
        n_vec++;
        if (ctrl_state !== 2'b00 || stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL halt_stall_first: st=%b cnt=%0d want 00/1",
                     ctrl_state, stall_cnt);
        end
        IDEX_MemRead = 1'b0;
        #1;
        n_vec++;
        if (PC_Write !== 1'b1) begin
            n_err++;
            $display("FAIL halt_entry_pc: pc=%b want 1", PC_Write);
        end
        step();
        idle_inputs();
        #1;
        n_vec++;
        if (ctrl_state !== 2'b10 || {PC_Write, IFID_Write, IDEX_Write,
            IFID_FLUSH, IDEX_FLUSH, EXM_FLUSH, alu_hold} !== 7'b0010100) begin
            n_err++;
            $display("FAIL halt_outs: st=%b outs=%b want 10/0010100",
                     ctrl_state, {PC_Write, IFID_Write, IDEX_Write,
                     IFID_FLUSH, IDEX_FLUSH, EXM_FLUSH, alu_hold});
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            branch_taken = i[0];
            md_start     = i[1];
            IDEX_MemRead = i[2];
            IDEX_RegRD   = 4'd2;
            IFID_RS      = 4'd2;
            step();
            if (ctrl_state !== 2'b10 || md_done !== 1'b0) bad++;
        end
        idle_inputs();
        n_vec++;
        if (bad != 0 || stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL halt_hold: bad=%0d cnt=%0d want 0/1", bad, stall_cnt);
        end
        do_reset();
        n_vec++;
        if (ctrl_state !== 2'b00 || stall_cnt !== 16'd0 || PC_Write !== 1'b1) begin
            n_err++;
            $display("FAIL halt_reset: st=%b cnt=%0d pc=%b want 00/0/1",
                     ctrl_state, stall_cnt, PC_Write);
        end
    endtask

    task automatic test_reset_in_md();
        int seen;
        do_reset();
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (ctrl_state !== 2'b01) begin
            n_err++;
            $display("FAIL md_abort_pre: st=%b want 01", ctrl_state);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_vec++;
        if (ctrl_state !== 2'b00 || md_done !== 1'b0 || PC_Write !== 1'b1) begin
            n_err++;
            $display("FAIL md_abort: st=%b done=%b pc=%b want 00/0/1",
                     ctrl_state, md_done, PC_Write);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (md_done !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL md_abort_nodone: %0d done pulses want 0", seen);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        step();
        test_reset();
        test_load_use();
        test_r0_exempt();
        test_branch_override();
        test_muldiv();
        test_halt();
        test_reset_in_md();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
